// File: rtl/fetch_queue_if.sv
// fetch_queue_if
// Decode-side handshake between the fetch queue and the ID stage.
//   id_valid      head entry valid for decode
//   id_ready      decode accepts the head entry
//   id_instr      head instruction
//   id_pc         head PC
//   id_pc_plus_4  id_pc + 4, wrapping at 2^XLEN
// Modports: master = fetch queue (drives the entry), slave = decode.
interface fetch_queue_if #(
   parameter int XLEN = 32
);
   logic            id_valid;
   logic            id_ready;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_pc_plus_4;

   modport master (
      output id_valid,
      output id_instr,
      output id_pc,
      output id_pc_plus_4,
      input  id_ready
   );

   modport slave (
      input  id_valid,
      input  id_instr,
      input  id_pc,
      input  id_pc_plus_4,
      output id_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// Sits between IF and ID. Tracks the single fetch in flight to the
// synchronous instruction memory (1-cycle read latency), buffers returned
// {pc, instruction} pairs in a DEPTH-entry FIFO and offers them to decode.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   fetch_pc      PC the IF stage is driving to instruction memory
//   fetch_valid   IF presents a fetch this cycle
//   imem_rdata    memory data for the address accepted last cycle
//   flush         branch taken; drop everything queued or in flight
//   fetch_stall   holds the PC register in IF
//   count         number of valid FIFO entries
//   id            decode handshake (fetch_queue_if.master)
//
// Optional build macro: FETCH_QUEUE_BYPASS_EN. When defined, a response
// arriving while the FIFO is empty is shown to decode combinationally in the
// same cycle and is only written if decode does not take it.
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [XLEN-1:0]          fetch_pc,
   input  logic                     fetch_valid,
   input  logic [XLEN-1:0]          imem_rdata,
   input  logic                     flush,
   output logic                     fetch_stall,
   output logic [$clog2(DEPTH):0]   count,
   fetch_queue_if.master            id
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];
   logic [AW-1:0]   head;
   logic [AW-1:0]   tail;
   logic [CW-1:0]   cnt;
   logic            inflight_v;
   logic [XLEN-1:0] inflight_pc;

   logic [CW:0]     occ;
   logic            fifo_nonempty;
   logic            accept;
   logic            resp;
   logic            push;
   logic            fifo_pop;

   // Credit rule: every in-flight fetch already owns a FIFO slot, so IF is
   // stalled as soon as queued plus in-flight entries fill the FIFO. This
   // looks only at registered state, never at id_ready.
   assign occ           = {1'b0, cnt} + {{CW{1'b0}}, inflight_v};
   assign fetch_stall   = (occ >= (CW+1)'(DEPTH));
   assign fifo_nonempty = (cnt != '0);
   assign accept        = fetch_valid && !fetch_stall && !flush;
   assign resp          = inflight_v && !flush;
   assign fifo_pop      = fifo_nonempty && id.id_ready;
   assign count         = cnt;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;

   // With an empty FIFO the returning response is forwarded straight to
   // decode; it only lands in storage if decode is not ready for it.
   assign bypass = !fifo_nonempty && resp;
   assign push   = resp && !(bypass && id.id_ready);

   always_comb begin
      id.id_valid = fifo_nonempty || bypass;
      id.id_instr = instr_mem[head];
      id.id_pc    = pc_mem[head];
      if (bypass) begin
         id.id_instr = imem_rdata;
         id.id_pc    = inflight_pc;
      end
   end
`else
   // Without bypass decode only ever sees the FIFO head; when empty the head
   // slot shows stale data with id_valid low.
   assign push = resp;

   always_comb begin
      id.id_valid = fifo_nonempty;
      id.id_instr = instr_mem[head];
      id.id_pc    = pc_mem[head];
   end
`endif

   assign id.id_pc_plus_4 = id.id_pc + XLEN'(4);

   // Main state update. Flush wins over everything else: the FIFO empties,
   // the in-flight fetch is forgotten, a response in this cycle is dropped
   // and a fetch presented in this cycle is not taken. A pop completing in
   // the flush cycle needs no action since the whole queue empties anyway.
   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head        <= '0;
         tail        <= '0;
         cnt         <= '0;
         inflight_v  <= 1'b0;
         inflight_pc <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem[i]    <= '0;
            instr_mem[i] <= '0;
         end
      end else if (flush) begin
         head       <= '0;
         tail       <= '0;
         cnt        <= '0;
         inflight_v <= 1'b0;
      end else begin
         inflight_v <= accept;
         if (accept) begin
            inflight_pc <= fetch_pc;
         end
         if (push) begin
            pc_mem[tail]    <= inflight_pc;
            instr_mem[tail] <= imem_rdata;
            tail            <= tail + AW'(1);
         end
         if (fifo_pop) begin
            head <= head + AW'(1);
         end
         case ({push, fifo_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // The credit rule should make this unreachable: a write into a full FIFO
   // that is not matched by a pop in the same cycle.
   assert property (@(posedge clk) disable iff (rst)
      !(push && !fifo_pop && (cnt == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue
// Self-checking bench for fetch_queue (DEPTH=4, XLEN=32). A queue-level
// reference model tracks the entries ID should see, the in-flight fetch and
// the stall. Directed scenarios are followed by a randomized run.
module tb_fetch_queue;

   localparam int DEPTH = 4;
   localparam int XLEN  = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [XLEN-1:0] fetch_pc = '0;
   logic            fetch_valid = 1'b0;
   logic [XLEN-1:0] imem_rdata = '0;
   logic            flush = 1'b0;
   logic            fetch_stall;
   logic [2:0]      count;

   fetch_queue_if #(.XLEN(XLEN)) idb ();

   fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_pc    (fetch_pc),
      .fetch_valid (fetch_valid),
      .imem_rdata  (imem_rdata),
      .flush       (flush),
      .fetch_stall (fetch_stall),
      .count       (count),
      .id          (idb.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        mq[$];
   bit          m_infl = 1'b0;
   logic [31:0] m_infl_pc = '0;
   bit          last_acc = 1'b0;

   logic [31:0] got_pc[$];
   logic [31:0] got_in[$];
   logic [31:0] got_p4[$];

   function automatic logic [31:0] mem(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic bit m_bypass();
      return BYP && (mq.size() == 0) && m_infl && !flush;
   endfunction

   function automatic bit m_valid();
      return (mq.size() != 0) || m_bypass();
   endfunction

   function automatic logic [31:0] m_pc();
      return (mq.size() != 0) ? mq[0].pc : m_infl_pc;
   endfunction

   function automatic logic [31:0] m_instr();
      return (mq.size() != 0) ? mq[0].instr : imem_rdata;
   endfunction

   function automatic bit m_stall();
      return (mq.size() + int'(m_infl)) >= DEPTH;
   endfunction

   // Advance one clock edge and move the reference model with it.
   task automatic tick();
      bit          pop, byp, acc, fl;
      logic [31:0] rd, fpc;
      pop = m_valid() && idb.id_ready;
      byp = m_bypass();
      acc = fetch_valid && !m_stall() && !flush;
      fl  = flush;
      rd  = imem_rdata;
      fpc = fetch_pc;
      @(posedge clk);
      if (fl) begin
         mq.delete();
         m_infl = 1'b0;
      end else begin
         if (pop && !byp) void'(mq.pop_front());
         if (m_infl && !(byp && pop)) mq.push_back('{m_infl_pc, rd});
         m_infl = acc;
         if (acc) m_infl_pc = fpc;
      end
      last_acc = acc;
      #1;
   endtask

   task automatic do_reset();
      fetch_valid   = 1'b0;
      flush         = 1'b0;
      imem_rdata    = '0;
      fetch_pc      = '0;
      idb.id_ready  = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #2;
      rst = 1'b0;
      mq.delete();
      m_infl    = 1'b0;
      m_infl_pc = '0;
      got_pc.delete();
      got_in.delete();
      got_p4.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idb.id_ready = 1'b0;
      #2;
      n_checks++; if (idb.id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_id_valid got %b expected 0", idb.id_valid); end
      n_checks++; if (idb.id_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_id_instr got %h expected 0", idb.id_instr); end
      n_checks++; if (idb.id_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_id_pc got %h expected 0", idb.id_pc); end
      n_checks++; if (idb.id_pc_plus_4 !== 32'h4) begin n_fail++; $display("[TB] FAIL reset_id_pc_plus_4 got %h expected 4", idb.id_pc_plus_4); end
      n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fetch_stall got %b expected 0", fetch_stall); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d expected 0", count); end
      rst = 1'b0;
   endtask

   task automatic test_in_order();
      do_reset();
      idb.id_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         fetch_valid = (c < 3);
         fetch_pc    = 32'(4 * c);
         imem_rdata  = m_infl ? (32'hA0 + m_infl_pc) : 32'h0;
         #1;
         n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL inorder_stall cycle %0d got %b expected 0", c, fetch_stall); end
         if (idb.id_valid && idb.id_ready) begin
            got_pc.push_back(idb.id_pc);
            got_in.push_back(idb.id_instr);
            got_p4.push_back(idb.id_pc_plus_4);
         end
         tick();
      end
      n_checks++; if (got_pc.size() != 3) begin n_fail++; $display("[TB] FAIL inorder_num_popped got %0d expected 3", got_pc.size()); end
      for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
         n_checks++; if (got_pc[i] !== 32'(4 * i)) begin n_fail++; $display("[TB] FAIL inorder_pc[%0d] got %h expected %h", i, got_pc[i], 32'(4 * i)); end
         n_checks++; if (got_in[i] !== 32'(32'hA0 + 4 * i)) begin n_fail++; $display("[TB] FAIL inorder_instr[%0d] got %h expected %h", i, got_in[i], 32'(32'hA0 + 4 * i)); end
         n_checks++; if (got_p4[i] !== 32'(4 * i + 4)) begin n_fail++; $display("[TB] FAIL inorder_pc_plus_4[%0d] got %h expected %h", i, got_p4[i], 32'(4 * i + 4)); end
      end
   endtask

   task automatic test_full_stall();
      do_reset();
      idb.id_ready = 1'b0;
      fetch_valid  = 1'b1;
      fetch_pc     = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         imem_rdata = m_infl ? mem(m_infl_pc) : 32'h0;
         tick();
         if (last_acc) fetch_pc = fetch_pc + 32'd4;
         if (c == 3) begin
            n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL full_stall_early got %b expected 0", fetch_stall); end
         end
         if (c == 4) begin
            n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall_on_credit got %b expected 1", fetch_stall); end
            n_checks++; if (count !== 3'd3) begin n_fail++; $display("[TB] FAIL full_count_at_stall got %0d expected 3", count); end
         end
      end
      n_checks++; if (count !== 3'd4) begin n_fail++; $display("[TB] FAIL full_count got %0d expected 4", count); end
      n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL full_stall_held got %b expected 1", fetch_stall); end
      n_checks++; if (idb.id_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL full_head_pc got %h expected 0", idb.id_pc); end
      n_checks++; if (idb.id_instr !== mem(32'h0)) begin n_fail++; $display("[TB] FAIL full_head_instr got %h expected %h", idb.id_instr, mem(32'h0)); end
   endtask

   // Continues from the full state left by test_full_stall.
   task automatic test_full_push_pop();
      idb.id_ready = 1'b1;
      imem_rdata   = 32'h0;
      tick();
      if (last_acc) fetch_pc = fetch_pc + 32'd4;
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("[TB] FAIL pp_count_after_pop got %0d expected 3", count); end
      n_checks++; if (idb.id_pc !== 32'h4) begin n_fail++; $display("[TB] FAIL pp_head_after_pop got %h expected 4", idb.id_pc); end
      idb.id_ready = 1'b0;
      tick();
      if (last_acc) fetch_pc = fetch_pc + 32'd4;
      n_checks++; if (fetch_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL pp_stall_with_inflight got %b expected 1", fetch_stall); end
      idb.id_ready = 1'b1;
      fetch_valid  = 1'b0;
      imem_rdata   = mem(m_infl_pc);
      tick();
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("[TB] FAIL pp_count_push_pop got %0d expected 3", count); end
      n_checks++; if (idb.id_pc !== 32'h8) begin n_fail++; $display("[TB] FAIL pp_head_push_pop got %h expected 8", idb.id_pc); end
      imem_rdata = 32'h0;
      got_pc.delete();
      got_in.delete();
      for (int c = 0; c < 8; c++) begin
         #1;
         if (idb.id_valid && idb.id_ready) begin
            got_pc.push_back(idb.id_pc);
            got_in.push_back(idb.id_instr);
         end
         tick();
      end
      n_checks++; if (got_pc.size() != 3) begin n_fail++; $display("[TB] FAIL pp_drain_num got %0d expected 3", got_pc.size()); end
      for (int i = 0; i < 3 && i < got_pc.size(); i++) begin
         n_checks++; if (got_pc[i] !== 32'(8 + 4 * i)) begin n_fail++; $display("[TB] FAIL pp_drain_pc[%0d] got %h expected %h", i, got_pc[i], 32'(8 + 4 * i)); end
         n_checks++; if (got_in[i] !== mem(32'(8 + 4 * i))) begin n_fail++; $display("[TB] FAIL pp_drain_instr[%0d] got %h expected %h", i, got_in[i], mem(32'(8 + 4 * i))); end
      end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL pp_drain_count got %0d expected 0", count); end
   endtask

   task automatic test_flush();
      bit          seen, saw_bad;
      logic [31:0] first_pc, first_in;
      do_reset();
      idb.id_ready = 1'b0;
      fetch_valid  = 1'b1;
      for (int c = 0; c < 4; c++) begin
         imem_rdata = m_infl ? mem(m_infl_pc) : 32'h0;
         tick();
         if (last_acc) fetch_pc = fetch_pc + 32'd4;
      end
      n_checks++; if (count !== 3'd3) begin n_fail++; $display("[TB] FAIL flush_pre_count got %0d expected 3", count); end
      flush      = 1'b1;
      imem_rdata = 32'hBAD;
      tick();
      flush = 1'b0;
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL flush_count got %0d expected 0", count); end
      n_checks++; if (idb.id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_id_valid got %b expected 0", idb.id_valid); end
      n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_stall got %b expected 0", fetch_stall); end
      fetch_pc     = 32'h100;
      idb.id_ready = 1'b1;
      seen    = 1'b0;
      saw_bad = 1'b0;
      first_pc = '0;
      first_in = '0;
      for (int c = 0; c < 6; c++) begin
         fetch_valid = (c == 0);
         imem_rdata  = m_infl ? mem(m_infl_pc) : 32'hBAD;
         #1;
         if (idb.id_valid && idb.id_instr == 32'hBAD) saw_bad = 1'b1;
         if (idb.id_valid && !seen) begin
            seen     = 1'b1;
            first_pc = idb.id_pc;
            first_in = idb.id_instr;
         end
         tick();
      end
      n_checks++; if (saw_bad !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_discarded_resp got %b expected 0", saw_bad); end
      n_checks++; if (first_pc !== 32'h100) begin n_fail++; $display("[TB] FAIL flush_next_pc got %h expected 100", first_pc); end
      n_checks++; if (first_in !== mem(32'h100)) begin n_fail++; $display("[TB] FAIL flush_next_instr got %h expected %h", first_in, mem(32'h100)); end
   endtask

   task automatic test_async_reset();
      do_reset();
      idb.id_ready = 1'b0;
      fetch_valid  = 1'b1;
      for (int c = 0; c < 3; c++) begin
         imem_rdata = m_infl ? mem(m_infl_pc) : 32'h0;
         tick();
         if (last_acc) fetch_pc = fetch_pc + 32'd4;
      end
      n_checks++; if (count !== 3'd2) begin n_fail++; $display("[TB] FAIL arst_pre_count got %0d expected 2", count); end
      #2;
      rst = 1'b1;
      #1;
      n_checks++; if (idb.id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_id_valid got %b expected 0", idb.id_valid); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL arst_count got %0d expected 0", count); end
      n_checks++; if (fetch_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL arst_stall got %b expected 0", fetch_stall); end
      #1;
      rst = 1'b0;
      mq.delete();
      m_infl = 1'b0;
      got_pc.delete();
      got_in.delete();
      fetch_pc     = 32'h0;
      idb.id_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         fetch_valid = (c < 2);
         imem_rdata  = m_infl ? mem(m_infl_pc) : 32'h0;
         #1;
         if (idb.id_valid && idb.id_ready) begin
            got_pc.push_back(idb.id_pc);
            got_in.push_back(idb.id_instr);
         end
         tick();
         if (last_acc) fetch_pc = fetch_pc + 32'd4;
      end
      n_checks++; if (got_pc.size() != 2) begin n_fail++; $display("[TB] FAIL arst_resume_num got %0d expected 2", got_pc.size()); end
      if (got_pc.size() > 0) begin
         n_checks++; if (got_pc[0] !== 32'h0) begin n_fail++; $display("[TB] FAIL arst_resume_pc got %h expected 0", got_pc[0]); end
         n_checks++; if (got_in[0] !== mem(32'h0)) begin n_fail++; $display("[TB] FAIL arst_resume_instr got %h expected %h", got_in[0], mem(32'h0)); end
      end
   endtask

   task automatic test_random();
      bit fl;
      do_reset();
      fetch_pc = 32'h0;
      for (int c = 0; c < 400; c++) begin
         fetch_valid  = ($urandom_range(0, 3) != 0);
         idb.id_ready = ($urandom_range(0, 4) < 3);
         flush        = ($urandom_range(0, 19) == 0);
         imem_rdata   = $urandom;
         #1;
         n_checks++; if (idb.id_valid !== m_valid()) begin n_fail++; $display("[TB] FAIL rand_id_valid cycle %0d got %b expected %b", c, idb.id_valid, m_valid()); end
         n_checks++; if (count !== 3'(mq.size())) begin n_fail++; $display("[TB] FAIL rand_count cycle %0d got %0d expected %0d", c, count, mq.size()); end
         n_checks++; if (fetch_stall !== m_stall()) begin n_fail++; $display("[TB] FAIL rand_stall cycle %0d got %b expected %b", c, fetch_stall, m_stall()); end
         if (m_valid()) begin
            n_checks++; if (idb.id_pc !== m_pc()) begin n_fail++; $display("[TB] FAIL rand_id_pc cycle %0d got %h expected %h", c, idb.id_pc, m_pc()); end
            n_checks++; if (idb.id_instr !== m_instr()) begin n_fail++; $display("[TB] FAIL rand_id_instr cycle %0d got %h expected %h", c, idb.id_instr, m_instr()); end
            n_checks++; if (idb.id_pc_plus_4 !== m_pc() + 32'd4) begin n_fail++; $display("[TB] FAIL rand_pc_plus_4 cycle %0d got %h expected %h", c, idb.id_pc_plus_4, m_pc() + 32'd4); end
         end
         fl = flush;
         tick();
         if (fl) fetch_pc = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
         else if (last_acc) fetch_pc = fetch_pc + 32'd4;
      end
      flush       = 1'b0;
      fetch_valid = 1'b0;
   endtask

`ifdef FETCH_QUEUE_BYPASS_EN
   task automatic test_bypass();
      do_reset();
      idb.id_ready = 1'b1;
      fetch_valid  = 1'b1;
      fetch_pc     = 32'h20;
      tick();
      fetch_valid = 1'b0;
      imem_rdata  = 32'hC0DE_0020;
      #1;
      n_checks++; if (idb.id_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_id_valid got %b expected 1", idb.id_valid); end
      n_checks++; if (idb.id_instr !== 32'hC0DE_0020) begin n_fail++; $display("[TB] FAIL byp_id_instr got %h expected c0de0020", idb.id_instr); end
      n_checks++; if (idb.id_pc !== 32'h20) begin n_fail++; $display("[TB] FAIL byp_id_pc got %h expected 20", idb.id_pc); end
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL byp_count got %0d expected 0", count); end
      tick();
      n_checks++; if (count !== 3'd0) begin n_fail++; $display("[TB] FAIL byp_count_after got %0d expected 0", count); end
      n_checks++; if (idb.id_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL byp_valid_after got %b expected 0", idb.id_valid); end
   endtask
`endif

   initial begin
      idb.id_ready = 1'b0;
      test_reset();
      test_in_order();
      test_full_stall();
      test_full_push_pop();
      test_flush();
      test_async_reset();
`ifdef FETCH_QUEUE_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule
